// File: rtl/uart_word_rx.sv
// uart_word_rx
//   UART receive front end that assembles BPS-bit words from consecutive bytes
//   (most significant byte first) and buffers them in a first-word-fall-through
//   FIFO with a valid/ready output handshake.
//
//   Optional feature macro: UART_RX_PARITY_EN
//     defined   -> 11-bit frames (start, 8 data, even parity, stop)
//     undefined -> 10-bit frames (start, 8 data, stop); no parity state exists
//
// Ports
//   in_clk        system clock
//   in_reset      asynchronous active-low reset
//   rx_serial     UART line, idle high, asynchronous to in_clk
//   out_word      FIFO head word, meaningful only while out_valid=1 (else 0)
//   out_valid     FIFO not empty
//   in_ready      consumer takes out_word this cycle (pop when out_valid=1)
//   fifo_level    number of words stored (0..FIFO_DEPTH)
//   frame_err     one-cycle pulse on bad stop bit (or bad parity)
//   timeout_drop  one-cycle pulse when a partial word times out
//   overflow      sticky, set when a complete word is lost to a full FIFO

module uart_word_rx #(
  parameter int CLKS_PER_BIT = 640,
  parameter int BPS          = 24,
  parameter int FIFO_DEPTH   = 4,
  parameter int TIMEOUT_CLKS = 32 * CLKS_PER_BIT
) (
  input  logic                             in_clk,
  input  logic                             in_reset,
  input  logic                             rx_serial,
  output logic [BPS-1:0]                   out_word,
  output logic                             out_valid,
  input  logic                             in_ready,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_level,
  output logic                             frame_err,
  output logic                             timeout_drop,
  output logic                             overflow
);

  localparam int CW  = $clog2(CLKS_PER_BIT);
  localparam int TW  = $clog2(TIMEOUT_CLKS + 1);
  localparam int LW  = $clog2(FIFO_DEPTH + 1);
  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam int NB  = BPS / 8;
  localparam int BIW = (NB > 1) ? $clog2(NB) : 1;

  localparam logic [CW-1:0]  HALF_M1   = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0]  FULL_M1   = CW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0]  TO_MAX    = TW'(TIMEOUT_CLKS);
  localparam logic [BIW-1:0] LAST_BYTE = BIW'(NB - 1);
  localparam logic [LW-1:0]  DEPTH_L   = LW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  // Receiver state
  logic           rx_s1_q, rx_s2_q, rx_prev_q;
  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [2:0]     bit_idx_q, bit_idx_d;
  logic [7:0]     shift_q, shift_d;
  logic [BIW-1:0] byte_idx_q, byte_idx_d;
  logic [BPS-1:0] word_q, word_d;
  logic           push_q, push_d;
  logic [TW-1:0]  to_cnt_q, to_cnt_d;
  logic           frame_err_q, frame_err_d;
  logic           timeout_drop_q, timeout_drop_d;
`ifdef UART_RX_PARITY_EN
  logic           par_bad_q, par_bad_d;
`endif

  // FIFO state
  logic [BPS-1:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]  level_q, level_d;
  logic           valid_q, valid_d;
  logic           overflow_q, overflow_d;

  logic           start_edge;
  logic           pop;
  logic           push_ok;
  logic [BPS-1:0] word_shift;

  // Falling edge on the synchronised line. Because it needs a 1 before the 0,
  // a line held low after a framing error cannot re-trigger a start.
  assign start_edge = rx_prev_q & ~rx_s2_q;

  generate
    if (BPS > 8) begin : g_wide
      assign word_shift = {word_q[BPS-9:0], shift_q};
    end else begin : g_byte
      assign word_shift = shift_q;
    end
  endgenerate

  // Receiver next-state logic
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    bit_idx_d      = bit_idx_q;
    shift_d        = shift_q;
    byte_idx_d     = byte_idx_q;
    word_d         = word_q;
    push_d         = 1'b0;
    to_cnt_d       = '0;
    frame_err_d    = 1'b0;
    timeout_drop_d = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_d      = par_bad_q;
`endif

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (start_edge) state_d = S_START;
      end
      S_START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d     = '0;
          bit_idx_d = '0;
          // A line back high at mid start bit is a glitch, not a frame.
          state_d   = rx_s2_q ? S_IDLE : S_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DATA: begin
        if (cnt_q == FULL_M1) begin
          cnt_d     = '0;
          shift_d   = {rx_s2_q, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (cnt_q == FULL_M1) begin
          cnt_d   = '0;
          state_d = S_STOP;
          // Even parity: data bits plus parity bit must XOR to 0.
          par_bad_d = ^{shift_q, rx_s2_q};
          if (^{shift_q, rx_s2_q}) begin
            frame_err_d = 1'b1;
            byte_idx_d  = '0;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`endif
      S_STOP: begin
        if (cnt_q == FULL_M1) begin
          cnt_d   = '0;
          state_d = S_IDLE;
`ifdef UART_RX_PARITY_EN
          if (par_bad_q) begin
            // Byte already rejected at the parity bit; just consume the stop.
            par_bad_d = 1'b0;
          end else
`endif
          if (rx_s2_q) begin
            word_d = word_shift;
            if (byte_idx_q == LAST_BYTE) begin
              byte_idx_d = '0;
              push_d     = 1'b1;
            end else begin
              byte_idx_d = byte_idx_q + 1'b1;
            end
          end else begin
            frame_err_d = 1'b1;
            byte_idx_d  = '0;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    // Inter-byte timeout: only counts while a partial word waits in IDLE.
    if (state_q == S_IDLE && byte_idx_q != '0 && !start_edge) begin
      to_cnt_d = to_cnt_q + 1'b1;
      if (to_cnt_d == TO_MAX) begin
        to_cnt_d       = '0;
        byte_idx_d     = '0;
        timeout_drop_d = 1'b1;
      end
    end
  end

  // FIFO next-state logic. A push into a full FIFO succeeds only when the
  // head is being popped in the same cycle.
  always_comb begin
    pop        = valid_q & in_ready;
    push_ok    = push_q & ((level_q != DEPTH_L) | pop);
    overflow_d = overflow_q | (push_q & (level_q == DEPTH_L) & ~pop);
    wr_ptr_d   = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d   = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    level_d    = level_q + LW'(push_ok) - LW'(pop);
    valid_d    = (level_d != '0);
  end

  always_ff @(posedge in_clk or negedge in_reset) begin
    if (!in_reset) begin
      rx_s1_q        <= 1'b1;
      rx_s2_q        <= 1'b1;
      rx_prev_q      <= 1'b1;
      state_q        <= S_IDLE;
      cnt_q          <= '0;
      bit_idx_q      <= '0;
      shift_q        <= '0;
      byte_idx_q     <= '0;
      word_q         <= '0;
      push_q         <= 1'b0;
      to_cnt_q       <= '0;
      frame_err_q    <= 1'b0;
      timeout_drop_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_q      <= 1'b0;
`endif
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      level_q        <= '0;
      valid_q        <= 1'b0;
      overflow_q     <= 1'b0;
    end else begin
      rx_s1_q        <= rx_serial;
      rx_s2_q        <= rx_s1_q;
      rx_prev_q      <= rx_s2_q;
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      bit_idx_q      <= bit_idx_d;
      shift_q        <= shift_d;
      byte_idx_q     <= byte_idx_d;
      word_q         <= word_d;
      push_q         <= push_d;
      to_cnt_q       <= to_cnt_d;
      frame_err_q    <= frame_err_d;
      timeout_drop_q <= timeout_drop_d;
`ifdef UART_RX_PARITY_EN
      par_bad_q      <= par_bad_d;
`endif
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      level_q        <= level_d;
      valid_q        <= valid_d;
      overflow_q     <= overflow_d;
    end
  end

  // Storage needs no reset: nothing is read unless the level says it is valid.
  always_ff @(posedge in_clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= word_q;
  end

  assign out_word     = valid_q ? mem_q[rd_ptr_q] : '0;
  assign out_valid    = valid_q;
  assign fifo_level   = level_q;
  assign frame_err    = frame_err_q;
  assign timeout_drop = timeout_drop_q;
  assign overflow     = overflow_q;

endmodule
